hazard_ctrl: RTL and testbench

- Pipeline hazard/stall scheduler for the 5-stage RV64I core.
- Sequences the IF/ID/EX/MEM pipeline registers: per-stage stall (hold) and flush (insert bubble) enables.
- Causes handled: load-use hazards the forwarding network cannot cover, multi-cycle mul/div occupancy of EX, data-memory wait states, and EX-resolved control redirects.
- Sits beside the forwarding unit; consumes the same ID/EX register indices.

---
 rtl/hazard_ctrl_if.sv | 40 ++++
 rtl/hazard_ctrl.sv | 137 +++++++++++++
 tb/tb_hazard_ctrl.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// Hazard scheduler interface: ID/EX/MEM hazard inputs and per-stage stall/flush controls.
// The master side belongs to the pipeline; hazard_ctrl uses the slave side.
interface hazard_ctrl_if #(
    parameter int unsigned RF_SIZE = 5
);
    logic               EnRs1_id;
    logic               EnRs2_id;
    logic [RF_SIZE-1:0] Rs1Idx_id;
    logic [RF_SIZE-1:0] Rs2Idx_id;
    logic               EnMemR_ex;
    logic [RF_SIZE-1:0] RdIdx_ex;
    logic               Redirect_ex;
    logic               MulDivStart_ex;
    logic               MulDivDone;
    logic               DmemReq_mem;
    logic               DmemReady;
    logic               Stall_if;
    logic               Stall_id;
    logic               Stall_ex;
    logic               Stall_mem;
    logic               Flush_id;
    logic               Flush_ex;
    logic               Flush_mem;
    logic               PcRedirect;
    logic               WaitTimeout;

    modport master (
        output EnRs1_id, EnRs2_id, Rs1Idx_id, Rs2Idx_id, EnMemR_ex, RdIdx_ex,
               Redirect_ex, MulDivStart_ex, MulDivDone, DmemReq_mem, DmemReady,
        input  Stall_if, Stall_id, Stall_ex, Stall_mem, Flush_id, Flush_ex, Flush_mem,
               PcRedirect, WaitTimeout
    );

    modport slave (
        input  EnRs1_id, EnRs2_id, Rs1Idx_id, Rs2Idx_id, EnMemR_ex, RdIdx_ex,
               Redirect_ex, MulDivStart_ex, MulDivDone, DmemReq_mem, DmemReady,
        output Stall_if, Stall_id, Stall_ex, Stall_mem, Flush_id, Flush_ex, Flush_mem,
               PcRedirect, WaitTimeout
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall scheduler for the 5-stage core with a sticky wait watchdog.
// Defining HAZARD_PERF_CNT_EN adds load-use/mem-wait/muldiv-wait/redirect event counters.
module hazard_ctrl #(
    parameter int unsigned WAIT_TIMEOUT = 255,
    parameter int unsigned TMO_W        = 8
) (
    input  logic        clk,
    input  logic        rst,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0] LoadUseCnt,
    output logic [31:0] MemWaitCnt,
    output logic [31:0] MulDivWaitCnt,
    output logic [31:0] RedirectCnt,
`endif
    hazard_ctrl_if.slave hz
);

    typedef enum logic [1:0] {StRun, StMemWait, StMulDivWait} state_e;

    state_e           state_q, state_d;
    logic [TMO_W-1:0] cnt_q, cnt_d;
    logic             timeout_q;

    logic lu, ms, eval_ctl, redir_act, lu_act;
    logic st_if, st_id, st_ex, st_mem, fl_id, fl_ex, fl_mem, pc_sel;

    assign ms = hz.DmemReq_mem & ~hz.DmemReady;
    assign lu = hz.EnMemR_ex & (hz.RdIdx_ex != '0) &
                ((hz.EnRs1_id & (hz.Rs1Idx_id == hz.RdIdx_ex)) |
                 (hz.EnRs2_id & (hz.Rs2Idx_id == hz.RdIdx_ex)));

    always_comb begin
        state_d   = state_q;
        eval_ctl  = 1'b0;
        st_if     = 1'b0;
        st_id     = 1'b0;
        st_ex     = 1'b0;
        st_mem    = 1'b0;
        fl_id     = 1'b0;
        fl_ex     = 1'b0;
        fl_mem    = 1'b0;
        pc_sel    = 1'b0;
        // MEM_WAIT releasing re-evaluates exactly as RUN, so both share one arm
        unique case (state_q)
            StRun, StMemWait: begin
                if (ms) begin
                    {st_if, st_id, st_ex, st_mem} = 4'b1111;
                    state_d = StMemWait;
                end else if (hz.MulDivStart_ex && !hz.MulDivDone) begin
                    {st_if, st_id, st_ex} = 3'b111;
                    fl_mem  = 1'b1;
                    state_d = StMulDivWait;
                end else begin
                    eval_ctl = 1'b1;
                    state_d  = StRun;
                end
            end
            StMulDivWait: begin
                if (ms) begin
                    {st_if, st_id, st_ex, st_mem} = 4'b1111;
                end else if (hz.MulDivDone) begin
                    eval_ctl = 1'b1;
                    state_d  = StRun;
                end else begin
                    {st_if, st_id, st_ex} = 3'b111;
                    fl_mem = 1'b1;
                end
            end
            default: state_d = StRun;
        endcase

        redir_act = eval_ctl & hz.Redirect_ex;
        lu_act    = eval_ctl & ~hz.Redirect_ex & lu;
        if (redir_act) begin
            pc_sel = 1'b1;
            fl_id  = 1'b1;
            fl_ex  = 1'b1;
        end
        if (lu_act) begin
            st_if = 1'b1;
            st_id = 1'b1;
            fl_ex = 1'b1;
        end
    end

    always_comb begin
        if (state_d == StRun) begin
            cnt_d = '0;
        end else if (state_q != StRun) begin
            cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        end else begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StRun;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if ((state_q != StRun) && (cnt_q == TMO_W'(WAIT_TIMEOUT))) begin
                timeout_q <= 1'b1;
            end
        end
    end

    // Reset forces every output low, including a watchdog flag not yet cleared
    assign hz.Stall_if    = st_if & ~rst;
    assign hz.Stall_id    = st_id & ~rst;
    assign hz.Stall_ex    = st_ex & ~rst;
    assign hz.Stall_mem   = st_mem & ~rst;
    assign hz.Flush_id    = fl_id & ~rst;
    assign hz.Flush_ex    = fl_ex & ~rst;
    assign hz.Flush_mem   = fl_mem & ~rst;
    assign hz.PcRedirect  = pc_sel & ~rst;
    assign hz.WaitTimeout = timeout_q & ~rst;

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            LoadUseCnt    <= '0;
            MemWaitCnt    <= '0;
            MulDivWaitCnt <= '0;
            RedirectCnt   <= '0;
        end else begin
            if (lu_act) LoadUseCnt <= LoadUseCnt + 32'd1;
            if (state_q == StMemWait) MemWaitCnt <= MemWaitCnt + 32'd1;
            if (state_q == StMulDivWait) MulDivWaitCnt <= MulDivWaitCnt + 32'd1;
            if (redir_act) RedirectCnt <= RedirectCnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed vectors with literal expectations plus a per-cycle model check.
// Covers HAZARD_PERF_CNT_EN counters when that macro is defined.
module tb_hazard_ctrl;

    localparam int unsigned WaitTimeout = 255;

    // Vector order: Stall_if Stall_id Stall_ex Stall_mem Flush_id Flush_ex Flush_mem PcRedirect WaitTimeout
    localparam logic [8:0] V0   = 9'b000000000;
    localparam logic [8:0] VLu  = 9'b110001000;
    localparam logic [8:0] VRd  = 9'b000011010;
    localparam logic [8:0] VMd  = 9'b111000100;
    localparam logic [8:0] VMs  = 9'b111100000;
    localparam logic [8:0] VTmo = 9'b000000001;

    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;

    hazard_ctrl_if #(.RF_SIZE(5)) hz ();

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] lu_cnt, mw_cnt, mdw_cnt, rd_cnt;
`endif

    hazard_ctrl #(
        .WAIT_TIMEOUT(WaitTimeout),
        .TMO_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
`ifdef HAZARD_PERF_CNT_EN
        .LoadUseCnt(lu_cnt),
        .MemWaitCnt(mw_cnt),
        .MulDivWaitCnt(mdw_cnt),
        .RedirectCnt(rd_cnt),
`endif
        .hz(hz)
    );

    always #5 clk = ~clk;

    logic [8:0] dv;
    assign dv = {hz.Stall_if, hz.Stall_id, hz.Stall_ex, hz.Stall_mem, hz.Flush_id,
                 hz.Flush_ex, hz.Flush_mem, hz.PcRedirect, hz.WaitTimeout};

    // Model: m_md = a mul/div is outstanding, m_wait = this cycle is a wait cycle,
    // m_cnt = consecutive wait cycles before this one.
    bit m_md = 0, m_wait = 0, m_tmo = 0;
    int m_cnt = 0;
    bit n_md, n_wait, n_tmo;
    int n_cnt;
    int unsigned m_lu = 0, m_mw = 0, m_mdw = 0, m_rd = 0;
    int unsigned n_lu, n_mw, n_mdw, n_rd;

    always @(negedge clk) begin
        bit ms, lu, ctl;
        logic [8:0] e;
        ms = hz.DmemReq_mem && !hz.DmemReady;
        lu = hz.EnMemR_ex && (hz.RdIdx_ex != 0) &&
             ((hz.EnRs1_id && hz.Rs1Idx_id == hz.RdIdx_ex) ||
              (hz.EnRs2_id && hz.Rs2Idx_id == hz.RdIdx_ex));
        e = V0;
        ctl = 0;
        n_md = m_md;
        if (ms) begin
            e[8:5] = 4'b1111;
        end else if (m_md ? !hz.MulDivDone : (hz.MulDivStart_ex && !hz.MulDivDone)) begin
            e[8:6] = 3'b111;
            e[2] = 1'b1;
            n_md = 1;
        end else begin
            n_md = 0;
            ctl = 1;
        end
        if (ctl && hz.Redirect_ex) begin
            e[4] = 1'b1; e[3] = 1'b1; e[1] = 1'b1;
        end else if (ctl && lu) begin
            e[8] = 1'b1; e[7] = 1'b1; e[3] = 1'b1;
        end
        e[0] = m_tmo;
        n_wait = ms || n_md;
        n_cnt = (n_wait && m_wait) ? m_cnt + 1 : 0;
        n_tmo = m_tmo || (m_wait && m_cnt >= int'(WaitTimeout));
        n_lu  = m_lu + ((ctl && !hz.Redirect_ex && lu) ? 1 : 0);
        n_rd  = m_rd + ((ctl && hz.Redirect_ex) ? 1 : 0);
        n_mw  = m_mw + ((m_wait && !m_md) ? 1 : 0);
        n_mdw = m_mdw + (m_md ? 1 : 0);
        if (rst) begin
            e = V0;
            n_md = 0; n_wait = 0; n_cnt = 0; n_tmo = 0;
            n_lu = 0; n_rd = 0; n_mw = 0; n_mdw = 0;
        end
        n_chk++;
        if (dv !== e) begin
            n_fail++;
            $display("FAIL model_cmp t=%0t: got %b expected %b", $time, dv, e);
        end
`ifdef HAZARD_PERF_CNT_EN
        n_chk++;
        if ({lu_cnt, mw_cnt, mdw_cnt, rd_cnt} !== {m_lu, m_mw, m_mdw, m_rd}) begin
            n_fail++;
            $display("FAIL perf_cmp t=%0t: got lu=%0d mw=%0d mdw=%0d rd=%0d expected %0d %0d %0d %0d",
                     $time, lu_cnt, mw_cnt, mdw_cnt, rd_cnt, m_lu, m_mw, m_mdw, m_rd);
        end
`endif
    end

    always @(posedge clk) begin
        m_md   <= n_md;
        m_wait <= n_wait;
        m_cnt  <= n_cnt;
        m_tmo  <= n_tmo;
        m_lu   <= n_lu;
        m_rd   <= n_rd;
        m_mw   <= n_mw;
        m_mdw  <= n_mdw;
    end

    task automatic cyc(input string name, input logic [8:0] exp);
        @(negedge clk);
        n_chk++;
        if (dv !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, dv, exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        hz.EnRs1_id = 0; hz.EnRs2_id = 0; hz.Rs1Idx_id = 0; hz.Rs2Idx_id = 0;
        hz.EnMemR_ex = 0; hz.RdIdx_ex = 0; hz.Redirect_ex = 0;
        hz.MulDivStart_ex = 0; hz.MulDivDone = 0; hz.DmemReq_mem = 0; hz.DmemReady = 0;
    endtask

    task automatic lu_in(input bit en1, input logic [4:0] r1, input bit en2,
                         input logic [4:0] r2, input logic [4:0] rd);
        hz.EnMemR_ex = 1; hz.RdIdx_ex = rd;
        hz.EnRs1_id = en1; hz.Rs1Idx_id = r1;
        hz.EnRs2_id = en2; hz.Rs2Idx_id = r2;
    endtask

    initial begin
        rst = 1;
        idle();
        lu_in(1, 5, 0, 0, 5);
        cyc("rst_gate", V0);
        cyc("rst_gate2", V0);
        rst = 0;
        idle();
        cyc("idle", V0);

        lu_in(1, 5, 0, 0, 5);
        cyc("lu_rs1", VLu);
        idle();
        cyc("lu_one_cycle", V0);
        lu_in(1, 0, 0, 0, 0);
        cyc("lu_x0", V0);
        lu_in(0, 0, 1, 7, 7);
        cyc("lu_rs2", VLu);
        lu_in(0, 5, 0, 0, 5);
        cyc("lu_rs1_unused", V0);

        lu_in(1, 5, 0, 0, 5);
        hz.Redirect_ex = 1;
        cyc("redir_over_lu", VRd);
        idle();
        hz.Redirect_ex = 1;
        cyc("redir_alone", VRd);
        idle();

        hz.MulDivStart_ex = 1;
        cyc("md_c1", VMd);
        cyc("md_c2", VMd);
        cyc("md_c3", VMd);
        hz.MulDivDone = 1;
        cyc("md_done", V0);
        idle();
        cyc("md_idle", V0);

        hz.MulDivStart_ex = 1; hz.MulDivDone = 1; hz.Redirect_ex = 1;
        cyc("md_same_cycle", VRd);
        idle();

        hz.MulDivStart_ex = 1;
        cyc("mdms_start", VMd);
        cyc("mdms_wait", VMd);
        hz.DmemReq_mem = 1; hz.MulDivDone = 1;
        cyc("mdms_ms1", VMs);
        cyc("mdms_ms2", VMs);
        hz.DmemReady = 1;
        cyc("mdms_release", V0);
        idle();
        cyc("mdms_idle", V0);

        lu_in(1, 9, 0, 0, 9);
        hz.DmemReq_mem = 1;
        cyc("ms_lu1", VMs);
        cyc("ms_lu2", VMs);
        hz.DmemReady = 1;
        cyc("ms_release_lu", VLu);
        idle();
        cyc("ms_idle", V0);

        hz.MulDivStart_ex = 1;
        cyc("rst_md_enter", VMd);
        rst = 1;
        cyc("rst_md_gate", V0);
        rst = 0;
        idle();
        cyc("rst_md_abandon", V0);

        hz.DmemReq_mem = 1;
        cyc("tmo_first", VMs);
        repeat (254) begin
            @(posedge clk);
            #1;
        end
        cyc("tmo_edge", VMs);
        hz.DmemReady = 1;
        cyc("tmo_release", V0);
        idle();
        cyc("tmo_set", VTmo);
        lu_in(0, 0, 1, 3, 3);
        cyc("tmo_sticky_lu", VLu | VTmo);
        idle();
        rst = 1;
        cyc("tmo_rst", V0);
        rst = 0;
        cyc("tmo_cleared", V0);
        cyc("tmo_cleared2", V0);

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
